// File: rtl/boot_load_ctrl.sv
// Power-up program loader: receives a framed word packet over the UART, writes it to
// instruction memory, answers ACK/NAK, and releases the CPU after a good load.
module boot_load_ctrl #(
    parameter int ADDR_W     = 14,
    parameter int START_ADDR = 0,
    parameter int TIMEOUT    = 2_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              clr_rx_rdy,
    output logic              trmt,
    output logic [7:0]        tx_data,
    input  logic              tx_done,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    output logic              boot_done,
    output logic              boot_err,
    output logic [3:0]        state_dbg
);

    typedef enum logic [3:0] {
        S_SYNC, S_CNT_H, S_CNT_L, S_BYTE, S_WRITE, S_CSUM, S_RESP, S_RESP_WAIT, S_RUN
    } state_t;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam logic [7:0]  ACK_BYTE  = 8'h06;
    localparam logic [7:0]  NAK_BYTE  = 8'h15;
    localparam logic [32:0] MAX_N     = 33'((64'd1 << ADDR_W) - 64'(START_ADDR));
    localparam logic [23:0] IDLE_LAST = 24'(TIMEOUT - 1);

    state_t              r_state, w_state;
    logic                r_guard;
    logic [7:0]          r_cnt_h, w_cnt_h;
    logic [15:0]         r_n, w_n;
    logic [15:0]         r_i, w_i;
    logic [1:0]          r_idx, w_idx;
    logic [23:0]         r_word, w_word;
    logic [7:0]          r_sum, w_sum;
    logic                r_ack, w_ack;
    logic [23:0]         r_idle, w_idle;
    logic                r_trmt, w_trmt;
    logic [7:0]          r_tx_data, w_tx_data;
    logic                r_we, w_we;
    logic [ADDR_W-1:0]   r_addr, w_addr;
    logic [31:0]         r_wdata, w_wdata;
    logic                r_cpu_rst_n, w_cpu_rst_n;
    logic                r_boot_done, w_boot_done;
    logic                r_boot_err, w_boot_err;
    logic                w_consume, w_accept, w_timed, w_timeout;
    logic [15:0]         w_cnt;

    // A byte is taken only in receiving states and never in the cycle right after a take.
    assign w_consume = (r_state == S_SYNC) || (r_state == S_CNT_H) || (r_state == S_CNT_L) ||
                       (r_state == S_BYTE) || (r_state == S_CSUM);
    assign w_accept  = w_consume && rx_rdy && !r_guard;
    assign w_timed   = (r_state == S_CNT_H) || (r_state == S_CNT_L) || (r_state == S_BYTE) ||
                       (r_state == S_WRITE) || (r_state == S_CSUM);
    assign w_timeout = w_timed && (r_state != S_WRITE) && !w_accept && (r_idle >= IDLE_LAST);
    assign w_cnt     = {r_cnt_h, rx_data};

    always_comb begin
        w_state     = r_state;
        w_cnt_h     = r_cnt_h;
        w_n         = r_n;
        w_i         = r_i;
        w_idx       = r_idx;
        w_word      = r_word;
        w_sum       = r_sum;
        w_ack       = r_ack;
        w_idle      = '0;
        w_trmt      = 1'b0;
        w_tx_data   = r_tx_data;
        w_we        = 1'b0;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_cpu_rst_n = r_cpu_rst_n;
        w_boot_done = r_boot_done;
        w_boot_err  = r_boot_err;

        if (w_timed) w_idle = w_accept ? 24'd0 : r_idle + 24'd1;

        case (r_state)
            S_SYNC: if (w_accept && rx_data == SYNC_BYTE) begin
                w_boot_err = 1'b0;
                w_sum      = '0;
                w_i        = '0;
                w_idx      = '0;
                w_state    = S_CNT_H;
            end
            S_CNT_H: if (w_accept) begin
                w_cnt_h = rx_data;
                w_state = S_CNT_L;
            end
            S_CNT_L: if (w_accept) begin
                w_n = w_cnt;
                if (w_cnt == 16'd0 || {17'd0, w_cnt} > MAX_N) begin
                    w_ack   = 1'b0;
                    w_state = S_RESP;
                end else begin
                    w_state = S_BYTE;
                end
            end
            S_BYTE: if (w_accept) begin
                w_word = {r_word[15:0], rx_data};
                w_sum  = r_sum + rx_data;
                w_idx  = r_idx + 2'd1;
                if (r_idx == 2'd3) begin
                    w_we    = 1'b1;
                    w_addr  = ADDR_W'(START_ADDR) + ADDR_W'(r_i);
                    w_wdata = {r_word, rx_data};
                    w_state = S_WRITE;
                end
            end
            S_WRITE: begin
                w_i     = r_i + 16'd1;
                w_state = (r_i + 16'd1 == r_n) ? S_CSUM : S_BYTE;
            end
            S_CSUM: if (w_accept) begin
                w_ack   = (rx_data == r_sum);
                w_state = S_RESP;
            end
            S_RESP: begin
                w_trmt    = 1'b1;
                w_tx_data = r_ack ? ACK_BYTE : NAK_BYTE;
                w_state   = S_RESP_WAIT;
            end
            S_RESP_WAIT: if (tx_done) begin
                if (r_ack) begin
                    w_boot_done = 1'b1;
                    w_cpu_rst_n = 1'b1;
                    w_state     = S_RUN;
                end else begin
                    w_boot_err = 1'b1;
                    w_state    = S_SYNC;
                end
            end
            S_RUN: ;
            default: w_state = S_SYNC;
        endcase

        if (w_timeout) begin
            w_ack   = 1'b0;
            w_state = S_RESP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_SYNC;
            r_guard     <= 1'b0;
            r_cnt_h     <= '0;
            r_n         <= '0;
            r_i         <= '0;
            r_idx       <= '0;
            r_word      <= '0;
            r_sum       <= '0;
            r_ack       <= 1'b0;
            r_idle      <= '0;
            r_trmt      <= 1'b0;
            r_tx_data   <= '0;
            r_we        <= 1'b0;
            r_addr      <= ADDR_W'(START_ADDR);
            r_wdata     <= '0;
            r_cpu_rst_n <= 1'b0;
            r_boot_done <= 1'b0;
            r_boot_err  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_guard     <= w_accept;
            r_cnt_h     <= w_cnt_h;
            r_n         <= w_n;
            r_i         <= w_i;
            r_idx       <= w_idx;
            r_word      <= w_word;
            r_sum       <= w_sum;
            r_ack       <= w_ack;
            r_idle      <= w_idle;
            r_trmt      <= w_trmt;
            r_tx_data   <= w_tx_data;
            r_we        <= w_we;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_cpu_rst_n <= w_cpu_rst_n;
            r_boot_done <= w_boot_done;
            r_boot_err  <= w_boot_err;
        end
    end

    assign clr_rx_rdy = w_accept;
    assign trmt       = r_trmt;
    assign tx_data    = r_tx_data;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_rst_n  = r_cpu_rst_n;
    assign boot_done  = r_boot_done;
    assign boot_err   = r_boot_err;
    assign state_dbg  = r_state;

endmodule
